// File: rtl/joystick_serial_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : joystick_serial_reader                                          |
// | Brief    : Scans two joysticks through a 16-bit 74HC165 chain and presents |
// |            the 16 active-low states atomically once per scan.              |
// |            Optional JOY_SCAN_DEGLITCH_EN: outputs only follow a shadow     |
// |            that matches the previous scan.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module joystick_serial_reader #(
    parameter int CLKDIV   = 14,
    parameter int GAPTICKS = 1000
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic joy_data,
    output logic joy_clk,
    output logic joy_load_n,
    output logic joy1up,
    output logic joy1down,
    output logic joy1left,
    output logic joy1right,
    output logic joy1fire1,
    output logic joy1fire2,
    output logic joy1fire3,
    output logic joy1start,
    output logic joy2up,
    output logic joy2down,
    output logic joy2left,
    output logic joy2right,
    output logic joy2fire1,
    output logic joy2fire2,
    output logic joy2fire3,
    output logic joy2start,
    output logic scan_done
);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_SHLO   = 3'd1,
        S_SHHI   = 3'd2,
        S_UPDATE = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam logic [7:0]  c_TICK_LAST = 8'(CLKDIV - 1);
    localparam logic [15:0] c_GAP_LAST  = 16'(GAPTICKS - 1);
    localparam bit          c_NO_GAP    = (GAPTICKS == 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_tick;
    logic [15:0] r_gap;
    logic [3:0]  r_idx;
    logic [1:0]  r_sync;
    logic [15:0] r_shadow;
    logic [15:0] r_joy;
    logic        r_clk;
    logic        r_load_n;
    logic        r_done;
    logic        w_tick_end;
    logic        w_clk;
    logic        w_load_n;
    logic        w_update;
    logic        w_joy_load;

    assign w_tick_end = (r_tick == c_TICK_LAST);
    assign w_update   = (r_state == S_UPDATE);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk       = 1'b0;
        w_load_n    = 1'b1;
        unique case (r_state)
            S_LOAD: begin
                w_load_n = 1'b0;
                if (w_tick_end) w_state_nxt = S_SHLO;
            end
            S_SHLO: begin
                if (w_tick_end) w_state_nxt = S_SHHI;
            end
            S_SHHI: begin
                w_clk = 1'b1;
                if (w_tick_end) w_state_nxt = (r_idx == 4'd15) ? S_UPDATE : S_SHLO;
            end
            S_UPDATE: begin
                w_state_nxt = c_NO_GAP ? S_LOAD : S_GAP;
            end
            S_GAP: begin
                if (w_tick_end && (r_gap == c_GAP_LAST)) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Tick timebase; UPDATE is a single sysclk cycle and restarts the count.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= 8'd0;
            r_gap  <= 16'd0;
            r_idx  <= 4'd0;
        end else begin
            r_tick <= (w_update || w_tick_end) ? 8'd0 : r_tick + 8'd1;
            if (w_update)                          r_gap <= 16'd0;
            else if (r_state == S_GAP && w_tick_end) r_gap <= r_gap + 16'd1;
            if (r_state == S_LOAD && w_tick_end)   r_idx <= 4'd0;
            else if (r_state == S_SHHI && w_tick_end && r_idx != 4'd15) r_idx <= r_idx + 4'd1;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b11;
            r_shadow <= 16'hFFFF;
            r_clk    <= 1'b0;
            r_load_n <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], joy_data};
            if (r_state == S_SHLO && w_tick_end) r_shadow[r_idx] <= r_sync[1];
            r_clk    <= w_clk;
            r_load_n <= w_load_n;
            r_done   <= w_update;
        end
    end

`ifdef JOY_SCAN_DEGLITCH_EN
    logic [15:0] r_prev;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 16'hFFFF;
        end else if (w_update) begin
            r_prev <= r_shadow;
        end
    end

    assign w_joy_load = (r_shadow == r_prev);
`else
    assign w_joy_load = 1'b1;
`endif

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_joy <= 16'hFFFF;
        end else if (w_update && w_joy_load) begin
            r_joy <= r_shadow;
        end
    end

    assign joy_clk    = r_clk;
    assign joy_load_n = r_load_n;
    assign scan_done  = r_done;
    assign joy1up     = r_joy[0];
    assign joy1down   = r_joy[1];
    assign joy1left   = r_joy[2];
    assign joy1right  = r_joy[3];
    assign joy1fire1  = r_joy[4];
    assign joy1fire2  = r_joy[5];
    assign joy1fire3  = r_joy[6];
    assign joy1start  = r_joy[7];
    assign joy2up     = r_joy[8];
    assign joy2down   = r_joy[9];
    assign joy2left   = r_joy[10];
    assign joy2right  = r_joy[11];
    assign joy2fire1  = r_joy[12];
    assign joy2fire2  = r_joy[13];
    assign joy2fire3  = r_joy[14];
    assign joy2start  = r_joy[15];

endmodule
`default_nettype wire

// File: tb/tb_joystick_serial_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_joystick_serial_reader                                       |
// | Brief    : Bench with a 74HC165 chain model and a scan-level output model. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_joystick_serial_reader;

    localparam int CLKDIV   = 4;
    localparam int GAPTICKS = 2;
    localparam int PERIOD   = (33 + GAPTICKS) * CLKDIV + 1;

    logic        sysclk  = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_data;
    logic        joy_clk, joy_load_n, scan_done;
    logic        joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2, joy1fire3, joy1start;
    logic        joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2, joy2fire3, joy2start;
    logic [15:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    joystick_serial_reader #(.CLKDIV(CLKDIV), .GAPTICKS(GAPTICKS)) u_dut (
        .sysclk(sysclk), .reset_n(reset_n), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load_n(joy_load_n),
        .joy1up(joy1up), .joy1down(joy1down), .joy1left(joy1left), .joy1right(joy1right),
        .joy1fire1(joy1fire1), .joy1fire2(joy1fire2), .joy1fire3(joy1fire3), .joy1start(joy1start),
        .joy2up(joy2up), .joy2down(joy2down), .joy2left(joy2left), .joy2right(joy2right),
        .joy2fire1(joy2fire1), .joy2fire2(joy2fire2), .joy2fire3(joy2fire3), .joy2start(joy2start),
        .scan_done(scan_done)
    );

    assign outs = {joy2start, joy2fire3, joy2fire2, joy2fire1, joy2right, joy2left, joy2down, joy2up,
                   joy1start, joy1fire3, joy1fire2, joy1fire1, joy1right, joy1left, joy1down, joy1up};

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 74HC165 chain: parallel load while load_n low, shift toward bit 0 on joy_clk rise.
    logic [15:0] pat = 16'hFFFF;
    logic [15:0] sr  = 16'hFFFF;
    logic [15:0] q_cap[$];

    always @(negedge joy_load_n or posedge joy_clk) begin
        if (!joy_load_n) begin
            sr = pat;
            q_cap.push_back(pat);
        end else begin
            sr = {1'b1, sr[15:1]};
        end
    end
    assign joy_data = sr[0];

    // Scan-level reference: each scan_done publishes the pattern loaded at its start.
    logic [15:0] m_exp  = 16'hFFFF;
    logic [15:0] m_prev = 16'hFFFF;
    logic [15:0] m_cap;
    logic        prev_load = 1'b1;
    logic        prev_clk  = 1'b0;
    int          since_rst, last_done, low_run, high_run, clk_pulses;
    bit          seen_load, seen_done;

    always @(negedge sysclk) begin
        if (!reset_n) begin
            since_rst = 0; last_done = 0; low_run = 0; high_run = 0; clk_pulses = 0;
            seen_load = 0; seen_done = 0;
            m_exp = 16'hFFFF; m_prev = 16'hFFFF;
            q_cap.delete();
            prev_load = 1'b1; prev_clk = 1'b0;
            check("rst_state", {joy_clk, joy_load_n, scan_done, outs}, {3'b010, 16'hFFFF});
        end else begin
            since_rst++;
            if (!joy_load_n) begin
                if (prev_load) begin
                    clk_pulses = 0;
                    if (!seen_load) check("load_after_rst", since_rst, 1);
                    seen_load = 1;
                end
                low_run++;
            end else if (!prev_load) begin
                check("load_width", low_run, CLKDIV);
                low_run = 0;
            end
            if (joy_clk) begin
                if (!prev_clk) clk_pulses++;
                high_run++;
            end else if (prev_clk) begin
                check("clk_width", high_run, CLKDIV);
                high_run = 0;
            end
            if (scan_done) begin
                check("clk_pulses", clk_pulses, 16);
                if (!seen_done) check("first_done", since_rst, 33 * CLKDIV + 1);
                else            check("period", since_rst - last_done, PERIOD);
                seen_done = 1;
                last_done = since_rst;
                if (q_cap.size() == 0) begin
                    check("cap_queue", q_cap.size(), 1);
                end else begin
                    m_cap = q_cap.pop_front();
`ifdef JOY_SCAN_DEGLITCH_EN
                    if (m_cap == m_prev) m_exp = m_cap;
                    m_prev = m_cap;
`else
                    m_exp = m_cap;
`endif
                end
            end
            check("outs", outs, m_exp);
            prev_load = joy_load_n;
            prev_clk  = joy_clk;
        end
    end

    // Waits for n events on the selected signal: 0 scan_done, 1 load_n fall, 2 joy_clk rise.
    task automatic wait_ev(input int sel, input int n, input int budget);
        int   seen = 0;
        int   cyc  = 0;
        logic prev, cur;
        prev = (sel == 1) ? joy_load_n : joy_clk;
        while (seen < n && cyc < budget) begin
            @(negedge sysclk);
            cyc++;
            cur = (sel == 0) ? scan_done : ((sel == 1) ? joy_load_n : joy_clk);
            if (sel == 0 ? cur : (sel == 1 ? (prev && !cur) : (!prev && cur))) seen++;
            prev = cur;
        end
        if (seen < n) check("timeout", seen, n);
    endtask

    task automatic pulse_reset();
        @(negedge sysclk);
        #3 reset_n = 1'b0;
        #1 check("rst_async", {joy_clk, joy_load_n, scan_done, outs}, {3'b010, 16'hFFFF});
        @(negedge sysclk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        #2 reset_n = 1'b1;
        wait_ev(0, 1, PERIOD + 10);

        pat = 16'hFFFE;
        wait_ev(0, 2, 2 * PERIOD + 10);
        check("joy1up_only", outs, 16'hFFFE);
        pat = 16'h7FFF;
        wait_ev(0, 2, 2 * PERIOD + 10);
        check("joy2start_only", outs, 16'h7FFF);

        pat = 16'hFFFF;
        wait_ev(0, 2, 2 * PERIOD + 10);
        wait_ev(1, 1, PERIOD + 10);
        wait_ev(2, 7, PERIOD + 10);
        pat = 16'h0000;
        wait_ev(0, 1, PERIOD + 10);
        check("mid_scan_done", outs, 16'hFFFF);
        wait_ev(0, 1, PERIOD + 10);
`ifndef JOY_SCAN_DEGLITCH_EN
        check("mid_next_scan", outs, 16'h0000);
`endif
        wait_ev(0, 1, PERIOD + 10);
        check("mid_settled", outs, 16'h0000);

        pat = 16'hFFFF;
        wait_ev(0, 2, 2 * PERIOD + 10);
        pat = 16'hFFEF;
        wait_ev(0, 1, PERIOD + 10);
        pat = 16'hFFFF;
`ifdef JOY_SCAN_DEGLITCH_EN
        check("glitch_fire1", joy1fire1, 1'b1);
`else
        check("glitch_fire1", joy1fire1, 1'b0);
`endif
        wait_ev(0, 1, PERIOD + 10);
        check("glitch_gone", joy1fire1, 1'b1);
        pat = 16'hFFEF;
        wait_ev(0, 2, 2 * PERIOD + 10);
        check("stable_fire1", joy1fire1, 1'b0);

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) != 0) pat = 16'($urandom);
            wait_ev(0, 1, PERIOD + 10);
        end

        // Reset during the inter-scan gap.
        pat = 16'($urandom) & 16'h7FFF;
        pulse_reset();
        wait_ev(0, 2, 2 * PERIOD + 10);
        check("post_gap_rst", outs, pat);

        // Reset in the middle of shifting bit 9.
        wait_ev(1, 1, PERIOD + 10);
        wait_ev(2, 9, PERIOD + 10);
        repeat (CLKDIV + 1) @(negedge sysclk);
        pat = 16'h5A3C;
        pulse_reset();
        @(negedge sysclk);
        check("post_mid_rst", outs, 16'hFFFF);
        wait_ev(0, 2, 2 * PERIOD + 10);
        check("after_mid_rst", outs, 16'h5A3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
